// File: rtl/timer_switch_pkg.sv
// Shared types for the multi-channel staircase timer.
// Holds the channel state encoding and the timer width helper.
package timer_switch_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    ON   = 2'd1,
    WARN = 2'd2
  } state_t;

  // Bits needed to hold ON_TIME-1, never less than one.
  function automatic int tw_of(input int on_time);
    int w;
    w = $clog2(on_time);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/timer_switch_channel.sv
// One staircase-light channel: OFF/ON/WARN FSM, countdown, blink.
// Ports: clock, reset_n, rise, all_off -> light, warn, remaining.
module timer_switch_channel
  import timer_switch_pkg::*;
#(
  parameter int ON_TIME   = 20,
  parameter int WARN_TIME = 4,
  parameter bit TOGGLE    = 1'b0,
  localparam int TW       = tw_of(ON_TIME)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          rise,
  input  logic          all_off,
  output logic          light,
  output logic          warn,
  output logic [TW-1:0] remaining
);

  localparam logic [TW-1:0] LOAD  = TW'(ON_TIME - 1);
  localparam logic [TW-1:0] WLAST =
    TW'((WARN_TIME > 0) ? WARN_TIME - 1 : 0);
  localparam bit HAS_WARN = (WARN_TIME > 0);

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          light_n, warn_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= OFF;
      timer <= '0;
      light <= 1'b0;
      warn  <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      light <= light_n;
      warn  <= warn_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    if (all_off) begin
      state_n = OFF;
      timer_n = '0;
    end else begin
      unique case (state)
        OFF: begin
          if (rise) begin
            state_n = ON;
            timer_n = LOAD;
          end
        end
        ON, WARN: begin
          if (rise) begin
            if (TOGGLE) begin
              state_n = OFF;
              timer_n = '0;
            end else begin
              state_n = ON;
              timer_n = LOAD;
            end
          end else if (timer == '0) begin
            state_n = OFF;
          end else begin
            timer_n = timer - 1'b1;
            if (HAS_WARN && timer_n == WLAST)
              state_n = WARN;
          end
        end
        default: begin
          state_n = OFF;
          timer_n = '0;
        end
      endcase
    end
  end

  // Blink index j = WLAST - timer; lit on odd j,
  // so the first warning cycle is dark.
  always_comb begin
    light_n = 1'b0;
    warn_n  = 1'b0;
    unique case (state_n)
      ON:      light_n = 1'b1;
      WARN: begin
        warn_n  = 1'b1;
        light_n = WLAST[0] ^ timer_n[0];
      end
      default: light_n = 1'b0;
    endcase
  end

  assign remaining = timer;

endmodule

// File: rtl/timer_switch_multi.sv
// Multi-channel staircase-light timer on the 1 Hz tick clock.
// Ports: clock, reset_n, btn, all_off -> light, warn, remaining, any_on.
module timer_switch_multi
  import timer_switch_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int ON_TIME   = 20,
  parameter int WARN_TIME = 4,
  parameter bit TOGGLE    = 1'b0,
  localparam int TW       = tw_of(ON_TIME)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [CHANNELS-1:0]    btn,
  input  logic                   all_off,
  output logic [CHANNELS-1:0]    light,
  output logic [CHANNELS-1:0]    warn,
  output logic [CHANNELS*TW-1:0] remaining,
  output logic                   any_on
);

  logic [CHANNELS-1:0] btn_q;
  logic [CHANNELS-1:0] rise;

  // Reset to ones: a button held through reset
  // release must not look like a fresh press.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) btn_q <= '1;
    else          btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_switch_channel #(
      .ON_TIME   (ON_TIME),
      .WARN_TIME (WARN_TIME),
      .TOGGLE    (TOGGLE)
    ) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .rise      (rise[i]),
      .all_off   (all_off),
      .light     (light[i]),
      .warn      (warn[i]),
      .remaining (remaining[i*TW +: TW])
    );
  end

  // A channel is non-OFF exactly when it is lit or
  // warning, so this is the OR of registered states.
  assign any_on = |(light | warn);

endmodule

// File: tb/tb_timer_switch_multi.sv
// Scoreboard bench for timer_switch_multi.
// Two instances: retrigger (a) and toggle (b).
module tb_timer_switch_multi;

  localparam int CH = 4;
  localparam int TW = 5;

  logic          clock;
  logic          reset_n;
  logic [CH-1:0] btn;
  logic          all_off;

  logic [CH-1:0]    light_a, warn_a, light_b, warn_b;
  logic [CH*TW-1:0] rem_a, rem_b;
  logic             any_a, any_b;

  timer_switch_multi #(
    .CHANNELS(CH), .ON_TIME(20), .WARN_TIME(4), .TOGGLE(1'b0)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .btn(btn),
    .all_off(all_off), .light(light_a), .warn(warn_a),
    .remaining(rem_a), .any_on(any_a)
  );

  timer_switch_multi #(
    .CHANNELS(CH), .ON_TIME(20), .WARN_TIME(4), .TOGGLE(1'b1)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .btn(btn),
    .all_off(all_off), .light(light_b), .warn(warn_b),
    .remaining(rem_b), .any_on(any_b)
  );

  typedef struct {
    int    cyc;
    int    dut;
    int    ch;
    bit    l;
    bit    w;
    int    rem;
    bit    chk_any;
    bit    any;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic push(input exp_t e);
    int idx;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > e.cyc) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic expect_ch(input int c, input int d,
                           input int ch, input bit l,
                           input bit w, input int rem,
                           input string nm);
    exp_t e;
    e = '{c, d, ch, l, w, rem, 1'b0, 1'b0, nm};
    push(e);
  endtask

  task automatic expect_all(input int c, input int d,
                            input int ch, input bit l,
                            input bit w, input int rem,
                            input bit any, input string nm);
    exp_t e;
    e = '{c, d, ch, l, w, rem, 1'b1, any, nm};
    push(e);
  endtask

  exp_t mon_e;
  bit   al, aw, aa, ok;
  int   ar;

  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.dut == 0) begin
        al = light_a[mon_e.ch];
        aw = warn_a[mon_e.ch];
        ar = int'(rem_a[mon_e.ch*TW +: TW]);
        aa = any_a;
      end else begin
        al = light_b[mon_e.ch];
        aw = warn_b[mon_e.ch];
        ar = int'(rem_b[mon_e.ch*TW +: TW]);
        aa = any_b;
      end
      ok = (al == mon_e.l) && (aw == mon_e.w) &&
           (ar == mon_e.rem) && (mon_e.cyc == cyc) &&
           (!mon_e.chk_any || aa == mon_e.any);
      checks++;
      if (ok) passes++;
      else
        $display({"FAIL %s cyc=%0d/%0d dut%0d ch%0d: ",
                  "got l=%b w=%b rem=%0d any=%b, ",
                  "want l=%b w=%b rem=%0d any=%b"},
                 mon_e.nm, cyc, mon_e.cyc, mon_e.dut,
                 mon_e.ch, al, aw, ar, aa, mon_e.l,
                 mon_e.w, mon_e.rem, mon_e.any);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [CH-1:0] m);
    btn = btn | m;
    tick();
    btn = btn & ~m;
  endtask

  int k, k2;

  initial begin
    reset_n = 1'b0;
    btn     = '0;
    all_off = 1'b0;

    tick();
    for (int d = 0; d < 2; d++)
      expect_all(cyc, d, 0, 0, 0, 0, 0, "rst_state");
    checks++;
    if (light_a === 4'b0000 && warn_a === 4'b0000 &&
        any_a === 1'b0)
      passes++;
    else
      $display("FAIL d_rst: l=%b w=%b any=%b, want 0",
               light_a, warn_a, any_a);
    reset_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++)
      expect_all(cyc, d, 0, 0, 0, 0, 0, "rel_first");
    checks++;
    if (light_b === 4'b0000 && any_b === 1'b0)
      passes++;
    else
      $display("FAIL d_rel: l=%b any=%b, want 0",
               light_b, any_b);
    tick();

    pulse(4'b0001);
    k = cyc;
    checks++;
    if (light_a[0] === 1'b1 && rem_a[TW-1:0] === 5'd19)
      passes++;
    else
      $display("FAIL d_t2: l=%b rem=%0d, want 1/19",
               light_a[0], rem_a[TW-1:0]);
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 20; n++)
        expect_ch(k + n, d, 0,
                  (n < 16) ? 1'b1 : bit'((n - 16) % 2),
                  (n >= 16), 19 - n, "t2_seq");
      expect_all(k + 20, d, 0, 0, 0, 0, 0, "t2_off");
    end
    repeat (22) tick();

    pulse(4'b0001);
    k = cyc;
    repeat (9) tick();
    expect_ch(k + 9, 0, 0, 1, 0, 10, "t3_mid");
    pulse(4'b0001);
    k2 = cyc;
    expect_ch(k2, 0, 0, 1, 0, 19, "t3_reload");
    expect_ch(k2 + 15, 0, 0, 1, 0, 4, "t3_lastlit");
    expect_ch(k2 + 16, 0, 0, 0, 1, 3, "t3_warn0");
    expect_ch(k2 + 19, 0, 0, 1, 1, 0, "t3_final");
    expect_all(k2 + 20, 0, 0, 0, 0, 0, 0, "t3_fall");
    expect_all(k2, 1, 0, 0, 0, 0, 0, "t3_tog_off");
    repeat (22) tick();

    pulse(4'b0001);
    k = cyc;
    repeat (19) tick();
    expect_ch(k + 19, 0, 0, 1, 1, 0, "rt_last");
    pulse(4'b0001);
    expect_ch(k + 20, 0, 0, 1, 0, 19, "rt_reload");
    expect_ch(k + 21, 0, 0, 1, 0, 18, "rt_next");
    expect_all(k + 20, 1, 0, 0, 0, 0, 0, "rt_tog");
    repeat (22) tick();

    pulse(4'b0010);
    k = cyc;
    repeat (4) tick();
    expect_ch(k + 4, 1, 1, 1, 0, 15, "t4_lit");
    pulse(4'b0010);
    checks++;
    if (light_b[1] === 1'b0 && any_b === 1'b0)
      passes++;
    else
      $display("FAIL d_t4: l=%b any=%b, want 0/0",
               light_b[1], any_b);
    expect_all(k + 5, 1, 1, 0, 0, 0, 0, "t4_toggle");
    expect_ch(k + 5, 0, 1, 1, 0, 19, "t4_reload");
    repeat (22) tick();

    pulse(4'b1100);
    k = cyc;
    repeat (7) tick();
    for (int d = 0; d < 2; d++) begin
      expect_ch(k + 7, d, 2, 1, 0, 12, "t5_ch2");
      expect_ch(k + 7, d, 3, 1, 0, 12, "t5_ch3");
    end
    btn[2]  = 1'b1;
    all_off = 1'b1;
    tick();
    btn[2]  = 1'b0;
    all_off = 1'b0;
    checks++;
    if (light_a === 4'b0000 && rem_a === '0 &&
        any_a === 1'b0)
      passes++;
    else
      $display("FAIL d_t5: l=%b rem=%h any=%b, want 0",
               light_a, rem_a, any_a);
    for (int d = 0; d < 2; d++) begin
      expect_all(k + 8, d, 2, 0, 0, 0, 0, "t5_off2");
      expect_all(k + 8, d, 3, 0, 0, 0, 0, "t5_off3");
      expect_ch(k + 9, d, 2, 0, 0, 0, "t5_stay");
    end
    repeat (3) tick();

    btn[0]  = 1'b1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      for (int d = 0; d < 2; d++)
        expect_all(cyc, d, 0, 0, 0, 0, 0, "t6_held");
    end
    btn[0] = 1'b0;
    tick();

    pulse(4'b0001);
    k = cyc;
    repeat (4) tick();
    expect_ch(k + 4, 0, 0, 1, 0, 15, "t6_lit");
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (light_a === 4'b0000 && warn_a === 4'b0000)
      passes++;
    else
      $display("FAIL d_t6: l=%b w=%b, want 0",
               light_a, warn_a);
    for (int d = 0; d < 2; d++)
      expect_all(k + 5, d, 0, 0, 0, 0, 0, "t6_async");
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    checks++;
    if (sb.size() == 0) passes++;
    else
      $display("FAIL sb_drain: %0d left, want 0",
               sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
